morse_stream_decoder: RTL and testbench
=======================================

# morse_stream_decoder

Streaming Morse decoder. It takes a serial stream of classified key symbols (dot, dash, letter gap, word gap) and accumulates each character in a shift register of parametrised depth. It decodes each character to ASCII and queues the result in an output FIFO behind a valid/ready handshake. It sits between the key-timing classifier and the display/UART path, replacing the fixed 8-bit, 4-symbol combinational decoder.

## Interface

Parameters:
- MAX_SYMS, 5: max dots/dashes per character; accumulator width is 2*MAX_SYMS; must be ≥4.
- FIFO_DEPTH, 4: output queue entries; must be ≥2.
- ERR_CHAR, 8'h3F: ASCII emitted for an unknown pattern or an overflowed pattern.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: reset, synchronous, active-low (rst==0 at a rising edge resets).
- sym_valid, in, 1: sym_code valid.
- sym_code, in, 2: 2'b00 dot, 2'b01 dash, 2'b10 letter gap, 2'b11 word gap.
- sym_ready, out, 1: symbol accepted on sym_valid && sym_ready.
- char_valid, out, 1: FIFO head valid.
- char_data, out, 8: ASCII at FIFO head; 8'h00 when char_valid==0.
- char_ready, in, 1: head popped on char_valid && char_ready.
- level, out, $clog2(FIFO_DEPTH+1): FIFO occupancy.
- err_cnt, out, 8: count of ERR_CHAR pushes, saturating at 8'hFF.

## Operation

- Accumulator encoding: 2 bits per element, 01 dot, 10 dash, 00 empty. The value is right-aligned; the newest element is in bits [1:0] and the first element is in the highest occupied pair. For example, 'A' = ...0110 and 'B' = 10010101.
- Dot/dash accepted with count<MAX_SYMS: acc <= {acc[2*MAX_SYMS-3:0], elem}, count+1.
- Dot/dash accepted with count==MAX_SYMS: acc and count unchanged; ovf flag set.
- Letter gap with count>0: push lut(acc), or ERR_CHAR if ovf. Then clear acc, count and ovf.
- Letter gap with count==0: no push.
- Word gap with count>0: push the character as above, then go to SPACE. The following cycle pushes 8'h20.
- Word gap with count==0: push 8'h20 unless the last pushed byte was 8'h20 (no duplicate spaces). A space is also suppressed when it would be the first push after reset.
- LUT contents: A–Z to 8'h41–8'h5A; 0–9 to 8'h30–8'h39 (5-element codes). Any other pattern returns ERR_CHAR.
- err_cnt increments on every ERR_CHAR push.
- FSM states:
  - IDLE (count==0): dot/dash goes to COLLECT.
  - COLLECT: letter gap goes to IDLE; word gap goes to SPACE.
  - SPACE: unconditional push of 8'h20, then go to IDLE.
- sym_ready = rst && state!=SPACE && (FIFO_DEPTH-level) ≥ 2. This guarantees room for a character plus a space.
- FIFO: simultaneous push and pop is allowed at any level, including full and empty, with level unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing

- Reset (rst==0 at an edge): state IDLE, acc/count/ovf 0, FIFO empty, level 0, char_valid 0, char_data 8'h00, err_cnt 0, sym_ready 0 while rst==0.
- Reset mid-character discards the partial character and all queued bytes.
- Letter gap accepted at edge N: the byte is written at N. With the FIFO empty before N, char_valid is high and char_data holds the byte in the cycle after N.
- Word gap with a pending character accepted at N: the character is written at N and the space at N+1. sym_ready is low in the cycle between N and N+1.
- Pop at edge M: the next head (or char_valid=0) is visible after M. Throughput is 1 symbol/cycle and 1 char/cycle.
- level updates at the same edge as the push or pop.
- sym_ready depends only on registered state and level, never on sym_valid.

## Structure

- Package morse_pkg:
  - symbol code constants SYM_DOT, SYM_DASH, SYM_LGAP, SYM_WGAP;
  - element encodings EL_DOT=2'b01, EL_DASH=2'b10;
  - FSM state enum;
  - ASCII_SPACE=8'h20.
- Sub-module morse_lut: combinational, parameter MAX_SYMS, input acc[2*MAX_SYMS-1:0], output ascii[7:0] and hit. The top applies ERR_CHAR when hit==0 or ovf.
- FIFO inline: register array, rd/wr pointers, level counter.

## Test plan

- Dot, dash, letter gap with char_ready=1: one char_valid pulse with char_data=8'h41; level returns to 0.
- Six dots then letter gap (MAX_SYMS=5): char_data=8'h3F, err_cnt=1. A following dot, letter gap yields 8'h45 (ovf cleared).
- Dot, word gap, word gap: queue receives 8'h45 then 8'h20 only. sym_ready is low exactly one cycle after the first word gap.
- char_ready=0 with FIFO_DEPTH=4 and three letters (E,T,I) queued: level=3 and sym_ready=0. One pop brings sym_ready back to 1 the next cycle.
- Dash, dash issued, then rst=0 for one edge: level=0, char_valid=0, err_cnt=0. The next dot, letter gap yields 8'h45 (no stale elements).
- Push and pop in the same cycle at level=FIFO_DEPTH-2: level unchanged, order preserved across pointer wrap over 10 characters.

Source files
------------

// File: rtl/morse_stream_decoder_pkg.sv
// Shared constants for the Morse stream decoder: symbol codes, element
// encodings, FSM states and the ASCII space byte.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LGAP = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  localparam logic [1:0] EL_DOT  = 2'b01;
  localparam logic [1:0] EL_DASH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SPACE   = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/morse_stream_decoder_lut.sv
// Combinational pattern-to-ASCII lookup for letters and digits.
// Patterns longer than five elements can never match, so they miss.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMS = 5
) (
  input  logic [2*MAX_SYMS-1:0] acc,
  output logic [7:0]            ascii,
  output logic                  hit
);

  localparam int AW = 2 * MAX_SYMS;
  localparam int KW = (AW < 10) ? AW : 10;

  logic [9:0] key;
  logic       high_clear;
  logic       found;

  assign key = 10'(acc[KW-1:0]);

  generate
    if (AW > 10) begin : g_wide
      assign high_clear = ~|acc[AW-1:10];
    end else begin : g_narrow
      assign high_clear = 1'b1;
    end
  endgenerate

  always_comb begin
    ascii = 8'h00;
    found = 1'b1;
    case (key)
      10'b00_00_00_01_10: ascii = 8'h41;
      10'b00_10_01_01_01: ascii = 8'h42;
      10'b00_10_01_10_01: ascii = 8'h43;
      10'b00_00_10_01_01: ascii = 8'h44;
      10'b00_00_00_00_01: ascii = 8'h45;
      10'b00_01_01_10_01: ascii = 8'h46;
      10'b00_00_10_10_01: ascii = 8'h47;
      10'b00_01_01_01_01: ascii = 8'h48;
      10'b00_00_00_01_01: ascii = 8'h49;
      10'b00_01_10_10_10: ascii = 8'h4A;
      10'b00_00_10_01_10: ascii = 8'h4B;
      10'b00_01_10_01_01: ascii = 8'h4C;
      10'b00_00_00_10_10: ascii = 8'h4D;
      10'b00_00_00_10_01: ascii = 8'h4E;
      10'b00_00_10_10_10: ascii = 8'h4F;
      10'b00_01_10_10_01: ascii = 8'h50;
      10'b00_10_10_01_10: ascii = 8'h51;
      10'b00_00_01_10_01: ascii = 8'h52;
      10'b00_00_01_01_01: ascii = 8'h53;
      10'b00_00_00_00_10: ascii = 8'h54;
      10'b00_00_01_01_10: ascii = 8'h55;
      10'b00_01_01_01_10: ascii = 8'h56;
      10'b00_00_01_10_10: ascii = 8'h57;
      10'b00_10_01_01_10: ascii = 8'h58;
      10'b00_10_01_10_10: ascii = 8'h59;
      10'b00_10_10_01_01: ascii = 8'h5A;
      10'b10_10_10_10_10: ascii = 8'h30;
      10'b01_10_10_10_10: ascii = 8'h31;
      10'b01_01_10_10_10: ascii = 8'h32;
      10'b01_01_01_10_10: ascii = 8'h33;
      10'b01_01_01_01_10: ascii = 8'h34;
      10'b01_01_01_01_01: ascii = 8'h35;
      10'b10_01_01_01_01: ascii = 8'h36;
      10'b10_10_01_01_01: ascii = 8'h37;
      10'b10_10_10_01_01: ascii = 8'h38;
      10'b10_10_10_10_01: ascii = 8'h39;
      default:            found = 1'b0;
    endcase
    hit = found && high_clear;
  end

endmodule

// File: rtl/morse_stream_decoder.sv
// Streaming Morse decoder: accumulates dot/dash elements per character,
// decodes on gaps and queues ASCII bytes behind a valid/ready FIFO.
//
// state   | meaning
// IDLE    | no elements collected for the current character
// COLLECT | at least one element collected
// SPACE   | character just pushed by a word gap; push a space this cycle
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int         MAX_SYMS   = 5,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ERR_CHAR   = 8'h3F
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sym_valid,
  input  logic [1:0]                         sym_code,
  output logic                               sym_ready,
  output logic                               char_valid,
  output logic [7:0]                         char_data,
  input  logic                               char_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic [7:0]                         err_cnt
);

  localparam int AW    = 2 * MAX_SYMS;
  localparam int CNT_W = $clog2(MAX_SYMS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SYMS);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ROOM = LVL_W'(FIFO_DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               last_space_q, last_space_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic [7:0] lut_ascii;
  logic       lut_hit;
  logic       char_err;
  logic [7:0] char_byte;
  logic       accept;
  logic       push;
  logic       push_err;
  logic [7:0] push_data;
  logic       do_push;
  logic       pop;

  morse_lut #(.MAX_SYMS(MAX_SYMS)) u_lut (
    .acc   (acc_q),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Gating on free space (not just "not full") leaves room for the
  // character and the trailing space a word gap may produce.
  assign sym_ready  = rst && (state_q != ST_SPACE) && (level_q <= LVL_ROOM);
  assign char_valid = (level_q != '0);
  assign char_data  = char_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level      = level_q;
  assign err_cnt    = err_cnt_q;
  assign accept     = sym_valid && sym_ready;
  assign pop        = char_valid && char_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_err  = 1'b0;
    push_data = 8'h00;
    char_err  = ovf_q || !lut_hit;
    char_byte = char_err ? ERR_CHAR : lut_ascii;

    if (state_q == ST_SPACE) begin
      push      = 1'b1;
      push_data = ASCII_SPACE;
      state_d   = ST_IDLE;
    end else if (accept) begin
      case (sym_code)
        SYM_DOT, SYM_DASH: begin
          state_d = ST_COLLECT;
          if (cnt_q != CNT_MAX) begin
            acc_d = {acc_q[AW-3:0], (sym_code == SYM_DOT) ? EL_DOT : EL_DASH};
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        SYM_LGAP: begin
          if (cnt_q != '0) begin
            push      = 1'b1;
            push_data = char_byte;
            push_err  = char_err;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ST_IDLE;
          end
        end
        SYM_WGAP: begin
          if (cnt_q != '0) begin
            push      = 1'b1;
            push_data = char_byte;
            push_err  = char_err;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = ST_SPACE;
          end else if (!last_space_q) begin
            push      = 1'b1;
            push_data = ASCII_SPACE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    do_push      = push && ((level_q != LVL_FULL) || pop);
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    last_space_d = last_space_q;
    err_cnt_d    = err_cnt_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      last_space_d    = (push_data == ASCII_SPACE);
      if (push_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({do_push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // last_space resets high so a leading word gap never emits a space.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      last_space_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      err_cnt_q    <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      last_space_q <= last_space_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      err_cnt_q    <= err_cnt_d;
      mem_q        <= mem_d;
    end
  end

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Bench for morse_stream_decoder: directed scenarios plus random symbol
// traffic, compared every cycle against a string/queue reference model.
module tb_morse_stream_decoder;

  localparam int MAX_SYMS   = 5;
  localparam int FIFO_DEPTH = 4;
  localparam logic [7:0] ERR = 8'h3F;

  localparam bit [1:0] C_DOT = 2'd0, C_DASH = 2'd1, C_LGAP = 2'd2, C_WGAP = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_code = 2'd0;
  logic       sym_ready;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready = 1'b0;
  logic [2:0] level;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  morse_stream_decoder #(
    .MAX_SYMS(MAX_SYMS), .FIFO_DEPTH(FIFO_DEPTH), .ERR_CHAR(ERR)
  ) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_ready(sym_ready), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .level(level), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  string morse_tbl [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."};

  // reference model state
  string      cur = "";
  bit         ovf = 1'b0;
  bit         space_pend = 1'b0;
  bit         last_space = 1'b1;
  int         errs = 0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    q.push_back(b);
    last_space = (b == 8'h20);
  endtask

  task automatic push_char();
    logic [7:0] b;
    bit hit;
    b = ERR;
    hit = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (morse_tbl[i] == cur) begin
        b = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
        hit = 1'b1;
      end
    end
    if (ovf || !hit) begin
      b = ERR;
      if (errs < 255) errs++;
    end
    push_byte(b);
    cur = "";
    ovf = 1'b0;
  endtask

  // Drive one cycle of inputs, compare outputs against the model, then
  // advance the model to the state after the coming rising edge.
  task automatic cyc(input bit v, input bit [1:0] c, input bit cr, input bit r);
    bit rdy;
    bit do_pop;
    @(negedge clk);
    sym_valid = v; sym_code = c; char_ready = cr; rst = r;
    #1;
    rdy = !space_pend && ((FIFO_DEPTH - q.size()) >= 2);
    chk("sym_ready", 32'(sym_ready), 32'(r && rdy));
    chk("char_valid", 32'(char_valid), 32'(q.size() > 0));
    chk("char_data", 32'(char_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
    chk("level", 32'(level), 32'(q.size()));
    chk("err_cnt", 32'(err_cnt), 32'(errs));
    if (!r) begin
      q.delete();
      cur = ""; ovf = 1'b0; space_pend = 1'b0; last_space = 1'b1; errs = 0;
    end else begin
      do_pop = (q.size() > 0) && cr;
      if (do_pop) void'(q.pop_front());
      if (space_pend) begin
        push_byte(8'h20);
        space_pend = 1'b0;
      end else if (v && rdy) begin
        case (c)
          C_DOT, C_DASH: begin
            if (cur.len() < MAX_SYMS) begin
              if (c == C_DOT) cur = {cur, "."};
              else cur = {cur, "-"};
            end else ovf = 1'b1;
          end
          C_LGAP: if (cur.len() > 0) push_char();
          default: begin
            if (cur.len() > 0) begin
              push_char();
              space_pend = 1'b1;
            end else if (!last_space) push_byte(8'h20);
          end
        endcase
      end
    end
  endtask

  initial begin
    int idx;
    string s;
    bit [1:0] code;
    int rr;

    repeat (2) @(posedge clk);
    cyc(0, C_DOT, 0, 0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(char_valid), 32'd0);
    chk("rst_ready", 32'(sym_ready), 32'd0);

    // 'A' with char_ready held high
    cyc(1, C_DOT, 1, 1); cyc(1, C_DASH, 1, 1); cyc(1, C_LGAP, 1, 1);
    cyc(0, C_DOT, 1, 1);
    chk("A_valid", 32'(char_valid), 32'd1);
    chk("A_data", 32'(char_data), 32'h41);
    cyc(0, C_DOT, 1, 1);
    chk("A_level", 32'(level), 32'd0);

    // overflow then recovery
    repeat (6) cyc(1, C_DOT, 1, 1);
    cyc(1, C_LGAP, 1, 1);
    cyc(0, C_DOT, 1, 1);
    chk("ovf_data", 32'(char_data), 32'h3F);
    chk("ovf_err", 32'(err_cnt), 32'd1);
    cyc(1, C_DOT, 1, 1); cyc(1, C_LGAP, 1, 1);
    cyc(0, C_DOT, 1, 1);
    chk("after_ovf_data", 32'(char_data), 32'h45);

    // dot, word gap, word gap
    cyc(1, C_DOT, 0, 1); cyc(1, C_WGAP, 0, 1);
    cyc(0, C_DOT, 0, 1);
    chk("space_ready_low", 32'(sym_ready), 32'd0);
    cyc(1, C_WGAP, 0, 1);
    chk("space_ready_back", 32'(sym_ready), 32'd1);
    chk("space_level", 32'(level), 32'd2);
    cyc(0, C_DOT, 0, 1);
    chk("no_dup_space", 32'(level), 32'd2);
    cyc(0, C_DOT, 1, 1);
    chk("wg_first", 32'(char_data), 32'h45);
    cyc(0, C_DOT, 1, 1);
    chk("wg_second", 32'(char_data), 32'h20);
    cyc(0, C_DOT, 0, 1);

    // backpressure: E, T, I queued
    cyc(1, C_DOT, 0, 1); cyc(1, C_LGAP, 0, 1);
    cyc(1, C_DASH, 0, 1); cyc(1, C_LGAP, 0, 1);
    cyc(1, C_DOT, 0, 1); cyc(1, C_DOT, 0, 1); cyc(1, C_LGAP, 0, 1);
    cyc(0, C_DOT, 0, 1);
    chk("bp_level", 32'(level), 32'd3);
    chk("bp_ready", 32'(sym_ready), 32'd0);
    cyc(0, C_DOT, 1, 1);
    cyc(0, C_DOT, 0, 1);
    chk("bp_ready_back", 32'(sym_ready), 32'd1);
    chk("bp_head", 32'(char_data), 32'h54);
    cyc(0, C_DOT, 1, 1); cyc(0, C_DOT, 1, 1); cyc(0, C_DOT, 0, 1);

    // reset mid-character with a byte queued and err_cnt nonzero
    cyc(1, C_DOT, 0, 1); cyc(1, C_LGAP, 0, 1);
    cyc(1, C_DASH, 0, 1); cyc(1, C_DASH, 0, 1);
    cyc(0, C_DOT, 0, 0);
    cyc(0, C_DOT, 0, 1);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    cyc(1, C_DOT, 1, 1); cyc(1, C_LGAP, 1, 1);
    cyc(0, C_DOT, 1, 1);
    chk("mid_rst_E", 32'(char_data), 32'h45);

    // simultaneous push/pop at level FIFO_DEPTH-2 across pointer wrap
    cyc(1, C_DOT, 0, 1); cyc(1, C_LGAP, 0, 1);
    cyc(1, C_DASH, 0, 1); cyc(1, C_LGAP, 0, 1);
    for (int k = 0; k < 10; k++) begin
      idx = $urandom_range(0, 35);
      s = morse_tbl[idx];
      for (int j = 0; j < s.len(); j++)
        cyc(1, (s[j] == 8'h2E) ? C_DOT : C_DASH, 0, 1);
      cyc(1, C_LGAP, 1, 1);
      cyc(0, C_DOT, 0, 1);
      chk("wrap_level", 32'(level), 32'd2);
    end
    cyc(0, C_DOT, 1, 1); cyc(0, C_DOT, 1, 1); cyc(0, C_DOT, 0, 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rr = $urandom_range(0, 9);
      code = (rr < 4) ? C_DOT : (rr < 7) ? C_DASH : (rr < 9) ? C_LGAP : C_WGAP;
      cyc($urandom_range(0, 3) != 0, code, $urandom_range(0, 2) != 0,
          $urandom_range(0, 299) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
